// File: rtl/input_port.sv
// Router input port: buffers link flits in a FIFO, locks a wormhole route from head to tail, emits tagged words.
// Latency: head pushed at edge N, route latched at N+1, tagged head on outData after N+2; then 1 flit/cycle.
// Backpressure: inReady = !full upstream; pops stall while portBlock[route] is high. Optional INPUT_PORT_STATS_EN builds flitCount.
module input_port #(
    parameter int flitWidth         = 16,
    parameter int flitWidthModified = 19,
    parameter int fifoDepth         = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inValid,
    input  logic [flitWidth-1:0]         inFlit,
    output logic                         inReady,
    input  logic [3:0]                   portBlock,
    output logic [flitWidthModified-1:0] outData,
    output logic                         errDrop,
    output logic [15:0]                  flitCount
);

    localparam int AW = $clog2(fifoDepth);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(fifoDepth);

    typedef enum logic {
        ST_IDLE,
        ST_FORWARD
    } state_t;

    logic [flitWidth-1:0]         mem_q [fifoDepth];
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    state_t                       state_q, state_d;
    logic [1:0]                   route_q, route_d;
    logic [flitWidthModified-1:0] out_data_q, out_data_d;
    logic                         err_drop_q, err_drop_d;

    logic                         full;
    logic                         empty;
    logic                         push;
    logic                         pop;
    logic [flitWidth-1:0]         front;

    // FIFO status and head-of-queue view; a full FIFO refuses pushes even if a pop happens this cycle
    always_comb begin
        full  = (count_q == CNT_FULL);
        empty = (count_q == '0);
        push  = inValid && !full;
        front = mem_q[rd_ptr_q];
    end

    assign inReady = !full;
    assign outData = out_data_q;
    assign errDrop = err_drop_q;

    // Route FSM: latch dest from head, forward until tail, discard orphan body flits while idle
    always_comb begin
        state_d    = state_q;
        route_d    = route_q;
        pop        = 1'b0;
        err_drop_d = 1'b0;
        // no pop: clear valid, keep route and flit fields as they were
        out_data_d = {out_data_q[flitWidthModified-1:flitWidth+1], 1'b0, out_data_q[flitWidth-1:0]};
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (front[flitWidth-1]) begin
                        route_d = front[flitWidth-3 -: 2];
                        state_d = ST_FORWARD;
                    end else begin
                        pop        = 1'b1;
                        err_drop_d = 1'b1;
                    end
                end
            end
            ST_FORWARD: begin
                // head bits seen here are ordinary payload; only TAIL ends the worm
                if (!empty && !portBlock[route_q]) begin
                    pop        = 1'b1;
                    out_data_d = {route_q, 1'b1, front};
                    if (front[flitWidth-2]) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= inFlit;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            route_q    <= 2'd0;
            out_data_q <= '0;
            err_drop_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            route_q    <= route_d;
            out_data_q <= out_data_d;
            err_drop_q <= err_drop_d;
        end
    end

`ifdef INPUT_PORT_STATS_EN
    logic        fwd_pop;
    logic [15:0] flit_count_q, flit_count_d;

    // Saturating count of flits forwarded downstream
    always_comb begin
        fwd_pop      = pop && (state_q == ST_FORWARD);
        flit_count_d = flit_count_q;
        if (fwd_pop && (flit_count_q != 16'hFFFF)) begin
            flit_count_d = flit_count_q + 16'd1;
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flit_count_q <= 16'd0;
        end else begin
            flit_count_q <= flit_count_d;
        end
    end

    assign flitCount = flit_count_q;
`else
    assign flitCount = 16'd0;
`endif

endmodule
